// File: rtl/tally_period_collector.sv
// Counts synchronized rising edges on four category inputs into four timed periods
// and packs the 16 saturating counts onto the 256-bit data_raw bus for the renderer.
module tally_period_collector #(
  parameter int unsigned TICKS_PER_SEC   = 100_000_000,
  parameter int unsigned SECS_PER_PERIOD = 10,
  parameter int unsigned MAX_COUNT       = 9999
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clear,
  input  logic [3:0]   evt,
  output logic [255:0] data_raw,
  output logic [1:0]   period_idx,
  output logic [7:0]   sec_left,
  output logic         running,
  output logic         done
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  prescaler;
  logic [3:0]     sync1, sync2, evt_q;
  logic [3:0]     evt_pulse;
  logic [15:0]    cnt [16];
  logic           sec_tick;
  logic           last_tick;
  logic           start_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      evt_q <= '0;
    end else begin
      sync1 <= evt;
      sync2 <= sync1;
      evt_q <= sync2;
    end
  end

  assign evt_pulse = sync2 & ~evt_q;
  assign sec_tick  = (state_q == RUN) && (prescaler == PW'(TICKS_PER_SEC - 1));
  assign last_tick = sec_tick && (sec_left == 8'd1) && (period_idx == 2'd3);
  assign start_run = !clear && start && (state_q != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_tick) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      period_idx <= '0;
      sec_left   <= 8'(SECS_PER_PERIOD);
    end else if (clear || start_run) begin
      prescaler  <= '0;
      period_idx <= '0;
      sec_left   <= 8'(SECS_PER_PERIOD);
    end else if (state_q == RUN) begin
      prescaler <= sec_tick ? '0 : prescaler + 1'b1;
      if (sec_tick) begin
        if (sec_left == 8'd1) begin
          if (period_idx != 2'd3) begin
            period_idx <= period_idx + 2'd1;
            sec_left   <= 8'(SECS_PER_PERIOD);
          end else begin
            sec_left <= '0;
          end
        end else begin
          sec_left <= sec_left - 8'd1;
        end
      end
    end
  end

  // Counting uses the pre-edge period_idx, so a rollover-cycle event lands in the old period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) cnt[i] <= '0;
    end else if (clear || start_run) begin
      for (int unsigned i = 0; i < 16; i++) cnt[i] <= '0;
    end else if (state_q == RUN) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (evt_pulse[i / 4] && (period_idx == 2'(i % 4)) && (cnt[i] != 16'(MAX_COUNT)))
          cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    data_raw = '0;
    for (int unsigned i = 0; i < 16; i++) data_raw[255 - 16*i -: 16] = cnt[i];
  end

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_tally_period_collector.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level
// model that derives period/seconds from elapsed RUN cycles.
module tb_tally_period_collector;

  localparam int unsigned T   = 4;
  localparam int unsigned S   = 2;
  localparam int unsigned MAX = 3;
  localparam int unsigned TS  = T * S;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic [3:0]   evt = '0;
  logic [255:0] data_raw;
  logic [1:0]   period_idx;
  logic [7:0]   sec_left;
  logic         running;
  logic         done;

  tally_period_collector #(
    .TICKS_PER_SEC(T),
    .SECS_PER_PERIOD(S),
    .MAX_COUNT(MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .clear(clear),
    .evt(evt),
    .data_raw(data_raw),
    .period_idx(period_idx),
    .sec_left(sec_left),
    .running(running),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: 0=idle 1=run 2=done; m_el = RUN cycles elapsed since the start edge.
  int          m_state;
  int          m_el;
  int          m_cnt [16];
  logic [3:0]  hist [3];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_el = 0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  // Raw level sampled at edge j-2 rising versus edge j-3 is the event seen at edge j.
  task automatic model_step();
    logic [3:0] p;
    int per;
    p = hist[1] & ~hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = evt;
    if (clear) begin
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      m_state = 0;
      m_el = 0;
    end else begin
      case (m_state)
        0: if (start) begin m_state = 1; m_el = 0; end
        1: begin
          per = m_el / TS;
          for (int c = 0; c < 4; c++)
            if (p[c] && m_cnt[c*4 + per] < MAX) m_cnt[c*4 + per]++;
          m_el++;
          if (m_el == 4 * TS) m_state = 2;
        end
        default: if (start) begin
          for (int i = 0; i < 16; i++) m_cnt[i] = 0;
          m_state = 1;
          m_el = 0;
        end
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    logic [255:0] exp_data;
    int exp_per, exp_sec;
    exp_data = '0;
    for (int i = 0; i < 16; i++) exp_data[255 - 16*i -: 16] = 16'(m_cnt[i]);
    exp_per = (m_state == 1) ? m_el / TS : (m_state == 2) ? 3 : 0;
    exp_sec = (m_state == 1) ? S - (m_el % TS) / T : 0;
    check({tag, ".data"}, data_raw, exp_data);
    check({tag, ".period"}, 256'(period_idx), 256'(exp_per));
    check({tag, ".running"}, 256'(running), 256'(m_state == 1));
    check({tag, ".done"}, 256'(done), 256'(m_state == 2));
    if (m_state != 0) check({tag, ".sec_left"}, 256'(sec_left), 256'(exp_sec));
  endtask

  task automatic cycle(input string tag, input logic [3:0] e, input logic s, input logic c);
    evt = e;
    start = s;
    clear = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.data", data_raw, '0);
    check("reset.period", 256'(period_idx), 256'd0);
    check("reset.sec_left", 256'(sec_left), 256'(S));
    check("reset.flags", 256'({running, done}), 256'd0);
    rst_n = 1'b1;

    // Edges without start are ignored.
    for (int i = 0; i < 5; i++) begin
      cycle("nostart", 4'h1, 1'b0, 1'b0);
      cycle("nostart", 4'h0, 1'b0, 1'b0);
    end
    idle_cycles("nostart", 3);
    check("nostart.data", data_raw, '0);

    // Three MEN edges in period 0.
    cycle("men", 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("men", 4'h1, 1'b0, 1'b0);
      cycle("men", 4'h0, 1'b0, 1'b0);
    end
    idle_cycles("men", 2);
    check("men.word0", 256'(data_raw[255:240]), 256'd3);
    check("men.rest", 256'(data_raw[239:0]), '0);

    // One WOMEN edge per period, then DONE.
    cycle("women", 4'h0, 1'b0, 1'b1);
    cycle("women", 4'h0, 1'b1, 1'b0);
    for (int k = 1; k <= 32; k++)
      cycle("women", (k % 8 == 2) ? 4'h2 : 4'h0, 1'b0, 1'b0);
    check("women.words4_7", 256'(data_raw[191:128]), 256'({16'd1, 16'd1, 16'd1, 16'd1}));
    check("women.done", 256'({done, running, period_idx}), 256'({1'b1, 1'b0, 2'd3}));
    idle_cycles("women.hold", 4);
    check("women.hold", 256'(data_raw[191:128]), 256'({16'd1, 16'd1, 16'd1, 16'd1}));

    // Four CHILD events in period 0 saturate at MAX; fresh start from DONE.
    for (int k = 0; k < 8; k++)
      cycle("sat", (k % 2 == 0) ? 4'h8 : 4'h0, (k == 0), 1'b0);
    idle_cycles("sat", 1);
    check("sat.word12", 256'(data_raw[63:48]), 256'(MAX));
    check("sat.words4_7_zeroed", 256'(data_raw[191:128]), '0);

    // CHILD event landing on the period-0 rollover edge stays in word 12.
    cycle("roll", 4'h0, 1'b0, 1'b1);
    cycle("roll", 4'h0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++)
      cycle("roll", (k >= 6 && k <= 8) ? 4'h8 : 4'h0, 1'b0, 1'b0);
    check("roll.word12", 256'(data_raw[63:48]), 256'd1);
    check("roll.word13", 256'(data_raw[47:32]), 256'd0);

    // All four categories rising together in period 0.
    cycle("all4", 4'h0, 1'b0, 1'b1);
    cycle("all4", 4'h0, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) cycle("all4", (k == 2) ? 4'hF : 4'h0, 1'b0, 1'b0);
    check("all4.w0", 256'(data_raw[255:240]), 256'd1);
    check("all4.w4", 256'(data_raw[191:176]), 256'd1);
    check("all4.w8", 256'(data_raw[127:112]), 256'd1);
    check("all4.w12", 256'(data_raw[63:48]), 256'd1);

    // clear beats start and a coincident event pulse.
    for (int k = 1; k <= 4; k++) cycle("clr", (k == 1) ? 4'h5 : 4'h0, (k == 1), 1'b0);
    cycle("clr", 4'hA, 1'b0, 1'b0);
    cycle("clr", 4'hA, 1'b0, 1'b0);
    cycle("clr", 4'hA, 1'b1, 1'b1);
    check("clr.data", data_raw, '0);
    check("clr.flags", 256'({running, done, period_idx}), 256'd0);
    idle_cycles("clr", 3);

    // Asynchronous reset mid-RUN.
    cycle("arst", 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < 11; k++) cycle("arst", (k % 2 == 0) ? 4'h3 : 4'h0, 1'b0, 1'b0);
    evt = '0; start = 1'b0; clear = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.data", data_raw, '0);
    check("arst.state", 256'({running, done, period_idx}), 256'd0);
    check("arst.sec_left", 256'(sec_left), 256'(S));
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle("rand", 4'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tally_period_collector.md
Name: tally_period_collector

Overview:
- Producer of the 256-bit `data_raw` bus consumed by the VGA text renderer.
- Counts rising edges on four category inputs (MEN, WOMEN, ELDERLY, CHILD) into one of four sequential timed periods.
- Packs the 16 resulting 16-bit counts into `data_raw`, in the word order the renderer expects.
- Sits between the board push-button/sensor inputs and the display path. Runs start → 4 periods → done, holding the results until cleared.

Parameters:
- TICKS_PER_SEC, 100_000_000, clk cycles per 1 s tick.
- SECS_PER_PERIOD, 10, seconds per period.
- MAX_COUNT, 9999, saturation value of each slot counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous pulse; begins collection from IDLE or DONE.
- clear  in  1  synchronous; zeroes all counts and returns to IDLE.
- evt  in  4  raw category inputs; bit0=MEN, bit1=WOMEN, bit2=ELDERLY, bit3=CHILD (asynchronous).
- data_raw  out  256  packed counts; word i = data_raw[255-16*i -: 16], i = cat*4 + period.
- period_idx  out  2  current period 0..3.
- sec_left  out  8  seconds remaining in current period.
- running  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst_n low, async):
  - all 16 counters = 0, so data_raw = 0.
  - period_idx = 0, sec_left = SECS_PER_PERIOD, running = 0, done = 0.
  - state = IDLE, tick prescaler = 0, synchronizer and edge flops = 0.
- Input conditioning:
  - each evt bit passes through a 2-flop synchronizer plus an edge register.
  - an event is the synchronized rising edge: a 1-cycle pulse, 3 cycles after the raw edge.
  - multiple bits rising in the same cycle each count.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start → RUN. On entry to RUN, prescaler = 0, period_idx = 0, sec_left = SECS_PER_PERIOD.
  - RUN:
    - prescaler counts 0..TICKS_PER_SEC-1 and produces a 1-cycle sec_tick on wrap.
    - each sec_tick decrements sec_left.
    - when sec_left = 1 and sec_tick fires:
      - if period_idx < 3: period_idx increments and sec_left reloads.
      - if period_idx = 3: state → DONE; period_idx stays 3 and sec_left = 0.
  - DONE: counts frozen; start → RUN with all counters zeroed (fresh run).
  - start while in RUN is ignored.
- Counting:
  - in RUN only, an event on category c increments word c*4 + period_idx.
  - counters saturate at MAX_COUNT: an increment at MAX_COUNT leaves the value unchanged (no wrap).
  - events in IDLE or DONE are ignored.
- Boundary conditions:
  - an event in the same cycle as a period rollover counts into the old period_idx.
  - an event in the cycle RUN → DONE still counts into period 3.
- clear:
  - has priority over start and over events in the same cycle.
  - zeroes counters, sets state = IDLE and period_idx = 0.
  - honoured in any state, including mid-period.
- Output timing:
  - data_raw is driven directly from the counter registers.
  - an event pulse at cycle n is visible at cycle n+1.
- Asynchronous reset mid-RUN aborts immediately to the reset values.

Test Plan (TICKS_PER_SEC=4, SECS_PER_PERIOD=2):
- Reset, then no start; toggle evt 5× → data_raw = 0, running = 0, period_idx = 0.
- start, 3 MEN edges in period 0 → word 0 = 3, all other words 0; data_raw[255:240] = 16'd3.
- start, one WOMEN edge in each period → words 4, 5, 6, 7 = 1 each. After 4×8 cycles done = 1, running = 0, period_idx = 3.
- Force word 12 to 9998 via 9998 CHILD edges (or TICKS_PER_SEC large), then 3 more edges → word 12 = 9999, no wrap.
- CHILD edge aligned with the rollover sec_tick 0→1 → counts in word 12, not 13. All four evt bits rise together → words 0, 4, 8, 12 each +1.
- clear asserted with start and an event mid-RUN → state IDLE, data_raw = 0. rst_n low mid-run → immediate reset values.
